// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave receiver and the master.
// Holds the receiver state encoding and the default frame length.
package spi_pkg;

  localparam int SPI_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_CS
  } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pin bundle plus the received-frame handshake.
// The slave modport is the receiver; master drives pins and consumes frames.
interface spi_slave_rx_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);

  logic             sclk;
  logic             cs;
  logic             mosi;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;

  modport slave (
    input  sclk,
    input  cs,
    input  mosi,
    input  dout_ready,
    output dout,
    output dout_valid,
    output frame_err,
    output overrun
  );

  modport master (
    output sclk,
    output cs,
    output mosi,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/spi_sync.sv
// N-flop synchronizer with rise/fall pulses on the synchronized value.
// RST_VAL sets the idle level the chain reports while in reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversampled sclk/cs/mosi, MSB-first frame assembly,
// single holding register with valid/ready, frame_err and overrun pulses.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q;
  logic [SYNC_STAGES-1:0] mosi_chain;

  spi_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sclk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.cs),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain[0] <= bus.mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_chain[i] <= mosi_chain[i-1];
      end
    end
  end

  assign mosi_q = mosi_chain[SYNC_STAGES-1];

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_q, sclk_rise};

  // The cs chain resets to "high", so a cs held low through reset would
  // look like a fresh fall; only arm once real samples show cs high.
  logic [SYNC_STAGES:0] fill;
  logic                 armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
      if (fill[SYNC_STAGES] && cs_q) begin
        armed <= 1'b1;
      end
    end
  end

  spi_state_e       state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] frame;
  logic             last;
  logic             clear, shift, done, err;

  assign frame = {shreg[WIDTH-2:0], mosi_q};
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    clear   = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_n = RECV;
          clear   = 1'b1;
        end
      end
      RECV: begin
        if (sclk_fall && last) begin
          done    = 1'b1;
          state_n = cs_rise ? IDLE : WAIT_CS;
        end else if (cs_rise) begin
          err     = 1'b1;
          state_n = IDLE;
        end else if (sclk_fall) begin
          shift = 1'b1;
        end
      end
      WAIT_CS: begin
        if (cs_q) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (shift || done) begin
      cnt   <= cnt + 1'b1;
      shreg <= frame;
    end
  end

  logic [WIDTH-1:0] dout_r;
  logic             valid_r;
  logic             ferr_r;
  logic             ovr_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      ferr_r <= err;
      ovr_r  <= done && valid_r && !bus.dout_ready;
      if (done && (!valid_r || bus.dout_ready)) begin
        dout_r  <= frame;
        valid_r <= 1'b1;
      end else if (valid_r && bus.dout_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = valid_r;
  assign bus.frame_err  = ferr_r;
  assign bus.overrun    = ovr_r;

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, frame length in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sclk/cs/mosi.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 The block SHALL have port cs  input  1  chip select, active-low.
REQ-007 The block SHALL have port mosi  input  1  serial data, MSB first, changed by master on sclk rising edge.
REQ-008 The block SHALL have port dout  output  WIDTH  received frame.
REQ-009 The block SHALL have port dout_valid  output  1  dout holds an unconsumed frame.
REQ-010 The block SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid&&dout_ready.
REQ-011 The block SHALL have port frame_err  output  1  one-clk pulse: cs deasserted before WIDTH bits.
REQ-012 The block SHALL have port overrun  output  1  one-clk pulse: completed frame dropped, holding register full.

Function
REQ-013 sclk, cs, mosi SHALL each pass through a SYNC_STAGES flop synchronizer before use; edges detected on synchronized values.
REQ-014 Operation SHALL be guaranteed when each sclk high and low phase lasts >= SYNC_STAGES+2 clk cycles.
REQ-015 mosi SHALL be sampled on each detected sclk falling edge while synchronized cs is low, shifted in MSB first.
REQ-016 FSM states SHALL be IDLE, RECV, WAIT_CS.
REQ-017 IDLE -> RECV when synchronized cs falls; bit counter cleared, shift register cleared.
REQ-018 RECV: each falling edge increments bit counter; on the WIDTH-th sample go to WAIT_CS and present frame for capture.
REQ-019 WAIT_CS: further sclk edges ignored; on cs rise go to IDLE.
REQ-020 RECV with cs rise before WIDTH samples SHALL pulse frame_err one clk, discard partial data, go to IDLE.
REQ-021 Completed frame SHALL load dout and set dout_valid on the clk edge after the cycle the WIDTH-th falling edge is detected.
REQ-022 dout and dout_valid SHALL hold stable until handshake; dout_valid clears on the clk edge where dout_valid&&dout_ready.
REQ-023 If a frame completes while dout_valid=1 and dout_ready=0 that cycle, overrun SHALL pulse one clk; old dout retained, new frame dropped.
REQ-024 If a frame completes in the same cycle as a handshake, new frame SHALL load and dout_valid stays 1, no overrun.
REQ-025 Simultaneous cs rise and WIDTH-th falling edge detection SHALL count as a complete frame.
REQ-026 Bit counter SHALL be $clog2(WIDTH+1) bits and never wrap within a frame.

Reset
REQ-027 rst SHALL force state IDLE, counter 0, shift register 0, dout 0, dout_valid 0, frame_err 0, overrun 0, synchronizers to cs=1, sclk=0, mosi=0.
REQ-028 rst asserted mid-frame SHALL discard the frame; after release a frame SHALL be recognised only from a new cs falling edge.

Structure
REQ-029 Package spi_pkg SHALL hold the state enum and default WIDTH constant, shared with spi_master.
REQ-030 Sub-module spi_sync (N-stage synchronizer plus rise/fall pulse outputs) SHALL be instantiated for sclk and cs; mosi uses synchronizer only.

Verification
REQ-031 Frame 12'hAAA, sclk = clk/8, dout_ready=1 -> dout=12'hAAA, dout_valid one clk, no errors.
REQ-032 Frames 12'h801 then 12'h7FE back-to-back, dout_ready=1 -> both delivered in order, MSB/LSB placement correct.
REQ-033 cs raised after 5 bits of 12'hFFF -> frame_err pulse, dout_valid stays 0, next 12'h123 received correctly.
REQ-034 dout_ready=0, frames 12'h111 then 12'h222 -> overrun pulse on second, dout remains 12'h111.
REQ-035 rst pulsed after 6 bits of 12'hABC, then full 12'h5A5 -> only 12'h5A5 delivered, no frame_err.
REQ-036 14 sclk cycles with cs low, data 12'hC3C then 2 extra bits -> dout=12'hC3C, extra bits ignored.
